// File: rtl/if_fetch_unit_if.sv
// Handshake bundles for the instruction-fetch stage:
// memory request/response port and fetch-to-decode port.
interface if_fetch_imem_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

interface if_fetch_id_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  modport master (
    output id_valid,
    output id_instr,
    output id_pc,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  id_instr,
    input  id_pc,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, credit-based request issue,
// in-order prefetch FIFO and redirect flush with stale-drop.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  if_fetch_imem_if.master   imem,
  if_fetch_id_if.master     id
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_live;
  logic [CW-1:0] r_drop;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_instr [FIFO_DEPTH];
  logic [31:0]   r_pc    [FIFO_DEPTH];

  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_drop_redir;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_inflight;
  logic          w_rsp;
  logic          w_rsp_live;
  logic          w_push;
  logic          w_pop;
  logic          w_id_valid;
  logic [31:0]   w_redir_pc;
  logic          w_unused;

  assign w_unused    = ^redirect_pc[1:0];
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};

  // Credits cover FIFO entries plus every outstanding response.
  assign w_sum       = SW'(r_count) + SW'(r_live) + SW'(r_drop);
  assign w_req_valid = !rst && (w_sum < SW'(FIFO_DEPTH));
  assign w_accept    = w_req_valid && imem.imem_req_ready;

  assign w_inflight  = (r_live != '0) || (r_drop != '0);
  assign w_rsp       = imem.imem_rsp_valid && w_inflight;
  assign w_rsp_live  = w_rsp && (r_drop == '0);
  assign w_push      = !rst && w_rsp_live && !redirect_valid;

  assign w_id_valid  = (r_count != '0);
  assign w_pop       = w_id_valid && id.id_ready;

  // Redirect folds live into drop; a same-cycle response retires one.
  assign w_drop_redir = SW'(r_drop) + SW'(r_live)
                      + SW'(w_accept) - SW'(w_rsp);

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_fetch_pc;

  assign id.id_valid = w_id_valid;
  assign id.id_instr = w_id_valid ? r_instr[r_rd_ptr] : '0;
  assign id.id_pc    = w_id_valid ? r_pc[r_rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_live     <= '0;
      r_drop     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redir_pc;
      r_rsp_pc   <= w_redir_pc;
      r_count    <= '0;
      r_live     <= '0;
      r_drop     <= CW'(w_drop_redir);
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_accept)
        r_fetch_pc <= r_fetch_pc + 32'd4;
      r_live <= r_live + CW'(w_accept)
              - CW'(w_rsp_live);
      r_drop <= r_drop - CW'(w_rsp && !w_rsp_live);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= imem.imem_rsp_data;
      r_pc[r_wr_ptr]    <= r_rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && r_count == CW'(FIFO_DEPTH)))
        else $error("prefetch FIFO overflow");
      assert (!(imem.imem_rsp_valid && !w_inflight))
        else $error("response with nothing in flight");
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a 1-cycle
// in-order memory model and a decode-side log.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  if_fetch_imem_if u_imem ();
  if_fetch_id_if   u_id ();

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0100),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (u_imem),
    .id             (u_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst_v, ready_v, idr_v, hold_v, redir_v;
  logic [31:0] redir_pc_v;
  logic [31:0] q[$];
  logic [31:0] acc_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic cycle();
    @(negedge clk);
    rst = rst_v;
    if (rst_v) q.delete();
    if (!rst_v && !hold_v && q.size() > 0) begin
      u_imem.imem_rsp_valid = 1'b1;
      u_imem.imem_rsp_data  = mem_word(q.pop_front());
    end else begin
      u_imem.imem_rsp_valid = 1'b0;
      u_imem.imem_rsp_data  = '0;
    end
    u_imem.imem_req_ready = ready_v;
    u_id.id_ready         = idr_v;
    redirect_valid        = redir_v;
    redirect_pc           = redir_pc_v;
    #1;
    if (u_imem.imem_req_valid && u_imem.imem_req_ready) begin
      q.push_back(u_imem.imem_req_addr);
      acc_log.push_back(u_imem.imem_req_addr);
    end
    if (u_id.id_valid && u_id.id_ready) begin
      got_pc.push_back(u_id.id_pc);
      got_ins.push_back(u_id.id_instr);
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    redir_v = 1'b0;
    hold_v = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst_v = 1'b0;
    acc_log.delete();
    got_pc.delete();
    got_ins.delete();
  endtask

  task automatic test_reset();
    rst_v = 1'b1; ready_v = 1'b1; idr_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (u_imem.imem_req_valid !== 1'b0 || u_id.id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valids: req_valid=%b id_valid=%b want 0 0",
                 u_imem.imem_req_valid, u_id.id_valid);
      end
    end
    n_checks++;
    if (u_id.id_instr !== 32'h0 || u_id.id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_id_data: instr=%h pc=%h want 0 0",
               u_id.id_instr, u_id.id_pc);
    end
    rst_v = 1'b0; ready_v = 1'b0;
    cycle();
    n_checks++;
    if (u_imem.imem_req_valid !== 1'b1 || u_imem.imem_req_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL first_req: valid=%b addr=%h want 1 00000100",
               u_imem.imem_req_valid, u_imem.imem_req_addr);
    end
    n_checks++;
    if (u_id.id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_id_valid: got %b want 0", u_id.id_valid);
    end
  endtask

  task automatic test_stream();
    ready_v = 1'b1; idr_v = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) cycle();
    n_checks++;
    if (got_pc.size() < 6) begin
      n_fail++;
      $display("FAIL stream_count: got %0d want >=6", got_pc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (got_pc[i] !== 32'h100 + 32'(4 * i) ||
            got_ins[i] !== mem_word(32'h100 + 32'(4 * i))) begin
          n_fail++;
          $display("FAIL stream_%0d: pc=%h instr=%h want pc=%h instr=%h",
                   i, got_pc[i], got_ins[i], 32'h100 + 32'(4 * i),
                   mem_word(32'h100 + 32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    ready_v = 1'b1; idr_v = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) cycle();
    n_checks++;
    if (acc_log.size() != 2 || u_imem.imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_credit: accepted=%0d req_valid=%b want 2 0",
               acc_log.size(), u_imem.imem_req_valid);
    end
    n_checks++;
    if (u_id.id_valid !== 1'b1 || u_id.id_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL bp_head: valid=%b pc=%h want 1 00000100",
               u_id.id_valid, u_id.id_pc);
    end
    idr_v = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    n_checks++;
    if (got_pc.size() < 3) begin
      n_fail++;
      $display("FAIL bp_release_count: got %0d want >=3", got_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_pc[i] !== 32'h100 + 32'(4 * i)) begin
          n_fail++;
          $display("FAIL bp_order_%0d: pc=%h want %h",
                   i, got_pc[i], 32'h100 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    ready_v = 1'b1; idr_v = 1'b1;
    do_reset();
    hold_v = 1'b1;
    cycle();
    cycle();
    cycle();
    n_checks++;
    if (acc_log.size() != 2 || u_imem.imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_setup: accepted=%0d req_valid=%b want 2 0",
               acc_log.size(), u_imem.imem_req_valid);
    end
    redir_v = 1'b1; redir_pc_v = 32'h0000_2002;
    cycle();
    redir_v = 1'b0; hold_v = 1'b0;
    got_pc.delete(); got_ins.delete();
    cycle();
    n_checks++;
    if (u_imem.imem_req_addr !== 32'h2000) begin
      n_fail++;
      $display("FAIL redir_addr: got %h want 00002000", u_imem.imem_req_addr);
    end
    for (int i = 0; i < 12; i++) cycle();
    n_checks++;
    if (got_pc.size() < 2) begin
      n_fail++;
      $display("FAIL redir_count: got %0d want >=2", got_pc.size());
    end else begin
      n_checks++;
      if (got_pc[0] !== 32'h2000 || got_ins[0] !== mem_word(32'h2000) ||
          got_pc[1] !== 32'h2004) begin
        n_fail++;
        $display("FAIL redir_first: pc0=%h ins0=%h pc1=%h want 2000 %h 2004",
                 got_pc[0], got_ins[0], got_pc[1], mem_word(32'h2000));
      end
    end
  endtask

  task automatic test_redirect_wrap();
    ready_v = 1'b1; idr_v = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    redir_v = 1'b1; redir_pc_v = 32'hFFFF_FFFC;
    cycle();
    redir_v = 1'b0;
    acc_log.delete(); got_pc.delete(); got_ins.delete();
    for (int i = 0; i < 12; i++) cycle();
    n_checks++;
    if (acc_log.size() < 2) begin
      n_fail++;
      $display("FAIL wrap_req_count: got %0d want >=2", acc_log.size());
    end else begin
      n_checks++;
      if (acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
        n_fail++;
        $display("FAIL wrap_req: %h %h want fffffffc 00000000",
                 acc_log[0], acc_log[1]);
      end
    end
    n_checks++;
    if (got_pc.size() < 2) begin
      n_fail++;
      $display("FAIL wrap_id_count: got %0d want >=2", got_pc.size());
    end else begin
      n_checks++;
      if (got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0 ||
          got_ins[1] !== mem_word(32'h0)) begin
        n_fail++;
        $display("FAIL wrap_id: pc0=%h pc1=%h ins1=%h want fffffffc 0 %h",
                 got_pc[0], got_pc[1], got_ins[1], mem_word(32'h0));
      end
    end
  endtask

  task automatic test_req_stall();
    ready_v = 1'b0; idr_v = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (u_imem.imem_req_valid !== 1'b1 || u_imem.imem_req_addr !== 32'h100 ||
          u_id.id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d: valid=%b addr=%h id_valid=%b want 1 100 0",
                 i, u_imem.imem_req_valid, u_imem.imem_req_addr, u_id.id_valid);
      end
    end
    ready_v = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    n_checks++;
    if (got_pc.size() < 3) begin
      n_fail++;
      $display("FAIL stall_resume_count: got %0d want >=3", got_pc.size());
    end else begin
      n_checks++;
      if (got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104 ||
          got_pc[2] !== 32'h108 || got_ins[2] !== mem_word(32'h108)) begin
        n_fail++;
        $display("FAIL stall_resume: %h %h %h ins2=%h want 100 104 108 %h",
                 got_pc[0], got_pc[1], got_pc[2], got_ins[2], mem_word(32'h108));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    u_imem.imem_req_ready = 1'b0;
    u_imem.imem_rsp_valid = 1'b0;
    u_imem.imem_rsp_data  = '0;
    u_id.id_ready = 1'b0;
    rst_v = 1'b1; ready_v = 1'b0; idr_v = 1'b0;
    hold_v = 1'b0; redir_v = 1'b0; redir_pc_v = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_wrap();
    test_req_stall();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
